// File: rtl/wb_write_queue.sv
// Write-back queue: merges ALU and load results into one in-order register-file write per cycle.
// Two edges from push to write port; stall asks producers to hold; overflow flags a dropped push.
module wb_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              stall,
  output logic              overflow,
  output logic [ADDR_W-1:0] dest_wb,
  output logic [DATA_W-1:0] result_wb,
  output logic              writeBackEn
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, alu_slot, idx;
  logic [CW-1:0]     count;
  logic [CW:0]       free;
  logic              pop, acc_mem, acc_alu, drop;
  logic [1:0]        n_push;

  // The slot being popped this edge counts as free, so a full queue still takes one push.
  always_comb begin
    pop      = (count != '0);
    free     = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    acc_mem  = mem_valid && (free != '0);
    acc_alu  = alu_valid && (free > (CW+1)'(acc_mem));
    drop     = (mem_valid && !acc_mem) || (alu_valid && !acc_alu);
    n_push   = {1'b0, acc_mem} + {1'b0, acc_alu};
    alu_slot = wr_ptr + PW'(acc_mem);
  end

  assign stall = (count > CW'(DEPTH - 2));

  always_comb begin
    hazard1 = writeBackEn && (dest_wb == src1);
    hazard2 = writeBackEn && (dest_wb == src2);
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (dest_q[idx] == src1) hazard1 = 1'b1;
        if (dest_q[idx] == src2) hazard2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      writeBackEn <= 1'b0;
      dest_wb     <= '0;
      result_wb   <= '0;
      overflow    <= 1'b0;
    end else begin
      writeBackEn <= pop;
      if (pop) begin
        dest_wb   <= dest_q[rd_ptr];
        result_wb <= data_q[rd_ptr];
        rd_ptr    <= rd_ptr + PW'(1);
      end
      wr_ptr <= wr_ptr + PW'(n_push);
      count  <= count - CW'(pop) + CW'(n_push);
      if (drop) overflow <= 1'b1;
    end
  end

  // Mem goes first as the older instruction; alu takes the following slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc_mem) begin
        dest_q[wr_ptr] <= mem_dest;
        data_q[wr_ptr] <= mem_result;
      end
      if (acc_alu) begin
        dest_q[alu_slot] <= alu_dest;
        data_q[alu_slot] <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized and directed bench for wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic [AW-1:0] alu_dest, mem_dest, src1, src2;
  logic [DW-1:0] alu_result, mem_result;
  logic          hazard1, hazard2, stall, overflow, writeBackEn;
  logic [AW-1:0] dest_wb;
  logic [DW-1:0] result_wb;

  wb_write_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_result(mem_result),
    .src1(src1), .src2(src2), .hazard1(hazard1), .hazard2(hazard2),
    .stall(stall), .overflow(overflow), .dest_wb(dest_wb),
    .result_wb(result_wb), .writeBackEn(writeBackEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] d;
    logic [DW-1:0] r;
  } ent_t;

  ent_t          q[$];
  logic          m_en, m_ovf;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_res;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hz(input logic [AW-1:0] s);
    logic h;
    h = m_en && (m_dest == s);
    foreach (q[i]) if (q[i].d == s) h = 1'b1;
    return h;
  endfunction

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mr,
                      input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] ar,
                      input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic r);
    int   free;
    ent_t e;
    mem_valid = mv; mem_dest = md; mem_result = mr;
    alu_valid = av; alu_dest = ad; alu_result = ar;
    src1 = s1; src2 = s2; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_en = 0; m_dest = '0; m_res = '0; m_ovf = 0;
    end else begin
      free = D - q.size() + ((q.size() != 0) ? 1 : 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        m_en = 1; m_dest = e.d; m_res = e.r;
      end else begin
        m_en = 0;
      end
      if (mv) begin
        if (free > 0) begin e.d = md; e.r = mr; q.push_back(e); free--; end
        else m_ovf = 1;
      end
      if (av) begin
        if (free > 0) begin e.d = ad; e.r = ar; q.push_back(e); free--; end
        else m_ovf = 1;
      end
    end
    @(negedge clk);
    check("writeBackEn", 64'(writeBackEn), 64'(m_en));
    check("dest_wb", 64'(dest_wb), 64'(m_dest));
    check("result_wb", 64'(result_wb), 64'(m_res));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("stall", 64'(stall), 64'(q.size() > D - 2));
    check("hazard1", 64'(hazard1), 64'(model_hz(s1)));
    check("hazard2", 64'(hazard2), 64'(model_hz(s2)));
  endtask

  task automatic idle(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    step(0, 0, 0, 0, 0, 0, s1, s2, 0);
  endtask

  initial begin
    m_en = 0; m_ovf = 0; m_dest = '0; m_res = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_en", 64'(writeBackEn), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);

    // Single push: visible on the write port after the second edge only.
    step(0, 0, 0, 1, 5, 32'h1234, 5, 0, 0);
    check("single_e0_en", 64'(writeBackEn), 64'd0);
    check("single_e0_hz", 64'(hazard1), 64'd1);
    idle(5, 0);
    check("single_e1_en", 64'(writeBackEn), 64'd1);
    check("single_e1_dest", 64'(dest_wb), 64'd5);
    check("single_e1_res", 64'(result_wb), 64'h1234);
    check("single_e1_hz", 64'(hazard1), 64'd1);
    idle(5, 0);
    check("single_e2_en", 64'(writeBackEn), 64'd0);
    check("single_e2_hz", 64'(hazard1), 64'd0);

    // Dual push: mem is older and written first.
    step(1, 2, 32'hAA, 1, 3, 32'hBB, 2, 3, 0);
    idle(2, 3);
    check("dual_first_dest", 64'(dest_wb), 64'd2);
    check("dual_first_res", 64'(result_wb), 64'hAA);
    idle(2, 3);
    check("dual_second_dest", 64'(dest_wb), 64'd3);
    check("dual_second_res", 64'(result_wb), 64'hBB);
    idle(0, 0);
    idle(0, 0);

    // Fill honouring stall, 16 entries so the pointers wrap several times.
    for (int n = 0; n < 16; ) begin
      if (q.size() > D - 2) begin
        idle(AW'(n), AW'(n + 1));
      end else begin
        step(1, AW'(n), 32'h100 + n, 1, AW'(n + 1), 32'h100 + n + 1, AW'(n), AW'(n + 1), 0);
        n += 2;
      end
    end
    check("fill_no_overflow", 64'(overflow), 64'd0);
    repeat (5) idle(0, 1);

    // Overflow: keep dual-pushing past full; last mem accepted, last alu dropped.
    for (int n = 0; n < 4; n++)
      step(1, AW'(8 + n), 32'h200 + n, 1, AW'(12 + n), 32'h300 + n, 11, 15, 0);
    check("ovf_set", 64'(overflow), 64'd1);
    repeat (6) idle(11, 15);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-stream with 3 entries queued and pushes presented.
    step(1, 1, 32'h11, 1, 2, 32'h22, 1, 2, 0);
    step(1, 3, 32'h33, 1, 4, 32'h44, 1, 2, 0);
    step(1, 5, 32'h55, 1, 6, 32'h66, 1, 2, 1);
    check("rst_mid_en", 64'(writeBackEn), 64'd0);
    check("rst_mid_dest", 64'(dest_wb), 64'd0);
    check("rst_mid_res", 64'(result_wb), 64'd0);
    check("rst_mid_ovf", 64'(overflow), 64'd0);
    check("rst_mid_stall", 64'(stall), 64'd0);
    repeat (3) idle(1, 5);
    check("rst_mid_quiet", 64'(writeBackEn), 64'd0);

    // Duplicate destination: hazard holds until the second write has been presented.
    step(0, 0, 0, 1, 7, 32'h1, 0, 7, 0);
    step(0, 0, 0, 1, 7, 32'h2, 0, 7, 0);
    check("dup_first_res", 64'(result_wb), 64'h1);
    idle(0, 7);
    check("dup_second_res", 64'(result_wb), 64'h2);
    check("dup_second_hz", 64'(hazard2), 64'd1);
    idle(0, 7);
    check("dup_clear_hz", 64'(hazard2), 64'd0);

    // Random traffic, mostly respecting stall, with occasional violations and resets.
    for (int c = 0; c < 400; c++) begin
      logic p;
      p = (q.size() > D - 2) ? ($urandom_range(7) == 0) : 1'b1;
      step(p && $urandom_range(1), AW'($urandom), $urandom,
           p && $urandom_range(1), AW'($urandom), $urandom,
           AW'($urandom), AW'($urandom), $urandom_range(60) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back queue feeding the register file's single write port (`dest_wb`, `result_wb`, `writeBackEn`). It accepts completed results from two producers, the EXE-stage ALU and the MEM-stage load path, which may finish in the same cycle. It drains them in order, one register write per cycle. It also exposes a per-source hazard query so decode can stall on registers with a write still pending.

## Interface
Parameters:
- `DATA_W`, 32, result width (matches register width)
- `ADDR_W`, 4, register address width
- `DEPTH`, 4, queue entries; power of two, ≥ 2

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `alu_valid`  in  1  ALU result push request
- `alu_dest`  in  ADDR_W  ALU destination register
- `alu_result`  in  DATA_W  ALU result
- `mem_valid`  in  1  load result push request
- `mem_dest`  in  ADDR_W  load destination register
- `mem_result`  in  DATA_W  load data
- `src1`, `src2`  in  ADDR_W  decode source registers for hazard query
- `hazard1`, `hazard2`  out  1  a pending write targets `src1` / `src2` (combinational)
- `stall`  out  1  fewer than 2 free entries (combinational)
- `overflow`  out  1  sticky; a push was dropped
- `dest_wb`  out  ADDR_W  register file write address (registered)
- `result_wb`  out  DATA_W  register file write data (registered)
- `writeBackEn`  out  1  register file write enable (registered)

## Operation
- Circular FIFO with read pointer, write pointer and count (`log2(DEPTH)+1` bits). Pointers wrap modulo DEPTH.
- **Push ordering:** when `mem_valid` and `alu_valid` are both high, the mem entry is enqueued first, as the older instruction. The alu entry goes in the next slot.
- **Free-space calculation:** free = DEPTH − count + pop, where pop = (count ≠ 0) this cycle.
- **Push acceptance:** each push is accepted in order while free slots remain. A push with no free slot is dropped, and `overflow` is set to 1 until `rst`.
- **Stall:** `stall` = (count > DEPTH−2). Producers are required to hold results while `stall` is high. `overflow` only signals a protocol violation.
- **Pop:** every cycle with count ≠ 0, the head entry is loaded into `dest_wb`/`result_wb`, `writeBackEn` is set to 1, and the read pointer advances.
- **Empty queue:** with count = 0, `writeBackEn` is set to 0. `dest_wb` and `result_wb` hold their previous values.
- **No bypass:** pop decisions use pre-edge queue state, so an entry pushed into an empty queue is not popped on the same edge.
- **Hazard query:** `hazardN` = 1 if any valid queue entry has dest == `srcN`, or if `writeBackEn` = 1 and `dest_wb` == `srcN`. Producer inputs in the current cycle are not included.
- **Duplicate destinations:** multiple pending writes to the same register are all performed, in order. The hazard stays high until the last one has left the output register.
- **Reset:** a rising edge with `rst` = 1 empties the queue and clears both pointers, count, `writeBackEn`, `dest_wb`, `result_wb` and `overflow` to 0. This discards in-flight entries and any pushes presented in that cycle.

## Timing
- **Minimum latency:** a push sampled at edge k produces `writeBackEn` = 1 with that entry during the cycle after edge k+1, i.e. 2 edges from `*_valid` to write-port visibility.
- **Throughput:** 1 write per cycle. A sustained 2 pushes per cycle fills the queue and raises `stall`.
- The register file consumes the write port during the cycle it is presented. Each entry is presented for exactly 1 cycle.
- **Simultaneous push and pop at count = DEPTH−1:** the pop frees one slot, giving free = 2, so both pushes are accepted.
- **Count = DEPTH with both pushes:** free = 1, so the mem push is accepted, the alu push is dropped, and `overflow` rises on the next edge.
- `hazardN` and `stall` are combinational from registered state and `srcN` only; there is no path from `*_valid`.

## Test plan
- **Reset:** reset mid-stream with 3 entries queued → after the edge, `writeBackEn` = 0, `dest_wb` = 0, `result_wb` = 0, `overflow` = 0, `stall` = 0; no further writes occur.
- **Single push:** `alu_valid` with dest 5, result 0x1234 at edge 0 → `writeBackEn` = 1, `dest_wb` = 5, `result_wb` = 0x1234 after edge 1 only; `hazard1` = 1 for `src1` = 5 from edge 0 through edge 1, then 0 after edge 2.
- **Dual push ordering:** mem(dest 2, 0xAA) and alu(dest 3, 0xBB) in the same cycle → writes r2 = 0xAA, then r3 = 0xBB on consecutive cycles.
- **Fill/stall:** dual pushes for 3 consecutive cycles, DEPTH = 4 → `stall` = 1 once count ≥ 3; a clean stream with no drops keeps `overflow` = 0; pointers wrap correctly over 10+ entries and the output order matches the input order.
- **Overflow:** force dual pushes while count = 4 → the mem entry is written later, the alu entry is never written, and `overflow` = 1 persists until `rst`.
- **Duplicate destination:** push dest 7 with 0x1 then dest 7 with 0x2 → two writes in order; `hazard2` (`src2` = 7) stays high until the 0x2 write has been presented.
